// File: rtl/regfile_pkg.sv
// Purpose : shared widths and FSM state encoding for the operand-fetch client.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/rf_bypass_slot.sv
// Purpose : one operand bypass slot: records a writeback that hits the source
//           register during the read-issue cycle, and picks forwarded or
//           register-file data at capture.
// Latency : flag/data registered on the ISSUE edge; operand_o is combinational.
// Backpressure: none; the slot simply holds its state until cleared.
// Ports   : clr_i (new fetch accepted), issue_i (FSM in ISSUE), src_i (latched
//           source), wb_* (writeback port), rf_data_i (RF read data), operand_o.
module rf_bypass_slot
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH-1:0] src_i,
  input  logic                  wb_valid_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic [DATA_WIDTH-1:0] operand_o
);

  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic                  hit;

  // The register file returns pre-write data on a same-cycle read+write, so a
  // write landing in the ISSUE cycle must be captured here instead.
  assign hit = issue_i && wb_valid_i && (wb_addr_i == src_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else if (clr_i) begin
      fwd_q      <= 1'b0;
    end else if (hit) begin
      fwd_q      <= 1'b1;
      fwd_data_q <= wb_data_i;
    end
  end

  assign operand_o = fwd_q ? fwd_data_q : rf_data_i;

endmodule

// File: rtl/regfile_operand_fetch.sv
// Purpose : operand-fetch client of the register file: accepts a two-source
//           request, issues one read, captures both operands (with same-cycle
//           writeback bypass) and holds them for execute; writebacks pass through.
// Latency : request accepted on edge 1, rf_rd during the next cycle, op_valid
//           high after edge 3; at most one fetch per 3 cycles.
// Backpressure: operands held stable while op_ready=0; req_ready=0 then.
// Ports   : req_* (decode), wb_* (writeback), op_* (execute), rf_* (register file).
module regfile_operand_fetch
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_src1,
  input  logic [ADDR_WIDTH-1:0] req_src2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic                  rf_en,
  output logic                  rf_rd,
  output logic                  rf_wr,
  output logic [ADDR_WIDTH-1:0] rf_sel_i,
  output logic [DATA_WIDTH-1:0] rf_ip,
  output logic [ADDR_WIDTH-1:0] rf_sel_o1,
  output logic [ADDR_WIDTH-1:0] rf_sel_o2,
  input  logic [DATA_WIDTH-1:0] rf_op1,
  input  logic [DATA_WIDTH-1:0] rf_op2
);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] src1_q, src2_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q;
  logic [DATA_WIDTH-1:0] op1_d, op2_d;
  logic                  op_valid_q;
  logic                  rf_rd_q;
  logic                  accept;
  logic                  in_issue;

  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && op_ready);
  assign accept    = req_valid && req_ready;
  assign in_issue  = (state_q == ST_ISSUE);

  rf_bypass_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (accept),
    .issue_i    (in_issue),
    .src_i      (src1_q),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .rf_data_i  (rf_op1),
    .operand_o  (op1_d)
  );

  rf_bypass_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (accept),
    .issue_i    (in_issue),
    .src_i      (src2_q),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .rf_data_i  (rf_op2),
    .operand_o  (op2_d)
  );

  // rf_rd_q is set on the edge entering ISSUE and cleared on the edge leaving
  // it, so the read strobe is exactly the ISSUE cycle and never back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      op_valid_q <= 1'b0;
      rf_rd_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            src1_q  <= req_src1;
            src2_q  <= req_src2;
            rf_rd_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rf_rd_q <= 1'b0;
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          op1_q      <= op1_d;
          op2_q      <= op2_d;
          op_valid_q <= 1'b1;
          state_q    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            if (req_valid) begin
              src1_q  <= req_src1;
              src2_q  <= req_src2;
              rf_rd_q <= 1'b1;
              state_q <= ST_ISSUE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_valid  = op_valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign rf_rd     = rf_rd_q;
  assign rf_sel_o1 = src1_q;
  assign rf_sel_o2 = src2_q;

  // Write port is a pure pass-through, forced quiet while reset is asserted.
  assign rf_en    = rst_n;
  assign rf_wr    = rst_n && wb_valid;
  assign rf_sel_i = rst_n ? wb_addr : '0;
  assign rf_ip    = rst_n ? wb_data : '0;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
module tb_regfile_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_src1, req_src2;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        op_valid, op_ready;
  logic [31:0] op1, op2;
  logic        rf_en, rf_rd, rf_wr;
  logic [3:0]  rf_sel_i, rf_sel_o1, rf_sel_o2;
  logic [31:0] rf_ip, rf_op1, rf_op2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op1       (op1),
    .op2       (op2),
    .rf_en     (rf_en),
    .rf_rd     (rf_rd),
    .rf_wr     (rf_wr),
    .rf_sel_i  (rf_sel_i),
    .rf_ip     (rf_ip),
    .rf_sel_o1 (rf_sel_o1),
    .rf_sel_o2 (rf_sel_o2),
    .rf_op1    (rf_op1),
    .rf_op2    (rf_op2)
  );

  // Register file model: registered read, old data on simultaneous read+write.
  logic [31:0] regs [16];
  always @(posedge clk) begin
    if (rf_wr) regs[rf_sel_i] <= rf_ip;
    if (rf_rd && rf_en) begin
      rf_op1 <= regs[rf_sel_o1];
      rf_op2 <= regs[rf_sel_o2];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_src1 = '0; req_src2 = '0;
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'hAAAA_5555; op_ready = 1'b1;
    rf_op1 = '0; rf_op2 = '0;
    tick(); tick();

    // Reset state, write port gated while in reset
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op1", op1, 0);
    chk("rst_rf_en", rf_en, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_ip", rf_ip, 0);
    chk("rst_sel_o1", rf_sel_o1, 0);
    rst_n = 1'b1;
    wb_valid = 1'b0;
    #1;
    chk("rel_rf_en", rf_en, 1);

    // Basic fetch: r3, r5
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEAD_BEEF; #1;
    chk("wb_pass_wr", rf_wr, 1);
    chk("wb_pass_sel", rf_sel_i, 3);
    chk("wb_pass_ip", rf_ip, 32'hDEAD_BEEF);
    tick();
    wb_addr = 4'd5; wb_data = 32'h1234_5678;
    tick();
    wb_valid = 1'b0;
    req_valid = 1'b1; req_src1 = 4'd3; req_src2 = 4'd5; #1;
    chk("idle_req_ready", req_ready, 1);
    tick();                                   // edge 1: accept
    req_valid = 1'b0;
    chk("b_e1_op_valid", op_valid, 0);
    chk("b_e1_rf_rd", rf_rd, 1);
    chk("b_e1_sel_o1", rf_sel_o1, 3);
    chk("b_e1_sel_o2", rf_sel_o2, 5);
    tick();                                   // edge 2: capture cycle
    chk("b_e2_op_valid", op_valid, 0);
    chk("b_e2_rf_rd", rf_rd, 0);
    tick();                                   // edge 3: hold
    chk("b_e3_op_valid", op_valid, 1);
    chk("b_op1", op1, 32'hDEAD_BEEF);
    chk("b_op2", op2, 32'h1234_5678);
    tick();
    chk("b_drop_op_valid", op_valid, 0);

    // Bypass in ISSUE, then no late forward from CAPTURE/HOLD writes
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h0000_0001;
    tick();
    wb_valid = 1'b0; op_ready = 1'b0;
    req_valid = 1'b1; req_src1 = 4'd7; req_src2 = 4'd7;
    tick();                                   // now in ISSUE
    req_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'hCAFE_F00D;
    tick();                                   // now in CAPTURE
    wb_data = 32'h0000_0055;
    tick();                                   // now in HOLD
    chk("byp_op1", op1, 32'hCAFE_F00D);
    chk("byp_op2", op2, 32'hCAFE_F00D);
    tick();
    wb_valid = 1'b0;
    chk("late_op1", op1, 32'hCAFE_F00D);
    chk("late_op2", op2, 32'hCAFE_F00D);

    // Backpressure: held stable, no accept while op_ready=0
    req_valid = 1'b1; req_src1 = 4'd3; req_src2 = 4'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_op_valid", op_valid, 1);
      chk("bp_op1", op1, 32'hCAFE_F00D);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rf_rd", rf_rd, 0);
    end
    op_ready = 1'b1; #1;
    chk("bp_rel_req_ready", req_ready, 1);
    tick();                                   // HOLD -> ISSUE
    chk("b2b1_op_valid", op_valid, 0);
    chk("b2b1_rf_rd", rf_rd, 1);
    req_src1 = 4'd5; req_src2 = 4'd3;         // queued next request
    req_valid = 1'b0;
    tick();
    chk("b2b1_c_rf_rd", rf_rd, 0);
    req_valid = 1'b1;
    tick();
    chk("b2b1_op_valid_h", op_valid, 1);
    chk("b2b1_op1", op1, 32'hDEAD_BEEF);
    chk("b2b1_op2", op2, 32'h1234_5678);

    // Back-to-back fetch with writebacks to r9 in every cycle
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'h9000_0000 + i; #1;
      chk("wt_rf_wr", rf_wr, 1);
      chk("wt_rf_ip", rf_ip, 32'h9000_0000 + i);
      chk("wt_rf_sel_i", rf_sel_i, 9);
      tick();
      if (i == 0) begin
        req_valid = 1'b0;
        chk("b2b2_rf_rd", rf_rd, 1);
        chk("b2b2_sel_o1", rf_sel_o1, 5);
      end
    end
    wb_valid = 1'b0;
    chk("b2b2_op_valid", op_valid, 1);
    chk("b2b2_op1", op1, 32'h1234_5678);
    chk("b2b2_op2", op2, 32'hDEAD_BEEF);
    tick();                                   // back to IDLE

    // Reset in the middle of a fetch
    req_valid = 1'b1; req_src1 = 4'd3; req_src2 = 4'd5;
    tick();                                   // ISSUE
    req_valid = 1'b0;
    tick();                                   // CAPTURE
    rst_n = 1'b0; #1;
    chk("mid_rst_op_valid", op_valid, 0);
    chk("mid_rst_op1", op1, 0);
    chk("mid_rst_op2", op2, 0);
    chk("mid_rst_rf_en", rf_en, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_op_valid", op_valid, 0);
      chk("post_rst_rf_rd", rf_rd, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
